// File: rtl/dflow_gen_pkg.sv
// Shared widths, pacer state encoding and tuple record layout
// for the dflow generator tuple path.
package dflow_gen_pkg;

    localparam int PKT_TUPLE_WIDTH = 104;
    localparam int PKT_LEN_WIDTH   = 16;
    localparam int RATE_FRAC_BITS  = 8;
    localparam int BUCKET_WIDTH    = 24;
    localparam int IFG_BYTES       = 20;

    localparam int BUCKET_BITS = BUCKET_WIDTH + RATE_FRAC_BITS;
    localparam int COST_WIDTH  = PKT_LEN_WIDTH + 1;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } pacer_state_e;

    typedef struct packed {
        logic [PKT_TUPLE_WIDTH-1:0] tuple;
        logic [PKT_LEN_WIDTH-1:0]   len;
    } tuple_rec_t;

endpackage

// File: rtl/dflow_token_bucket.sv
// Fixed-point token bucket: refill by cfg_rate, debit on release,
// clamp to [0, cap], and decide whether the held record may go.
module dflow_token_bucket
    import dflow_gen_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_enable,
    input  logic [15:0]             cfg_rate,
    input  logic [BUCKET_WIDTH-1:0] cfg_burst,
    input  logic [COST_WIDTH-1:0]   cost,
    input  logic                    release_i,
    output logic                    token_ok
);

    localparam int SW = BUCKET_BITS + 1;

    logic [BUCKET_BITS-1:0]  bucket_q;
    logic [BUCKET_BITS-1:0]  bucket_d;
    logic [BUCKET_BITS-1:0]  cap;
    logic [SW-1:0]           sum_w;
    logic [SW-1:0]           sub_w;
    logic [SW-1:0]           diff_w;
    logic [BUCKET_WIDTH-1:0] bucket_int;
    logic [BUCKET_WIDTH-1:0] cost_ext;
    logic                    oversize;

    always_comb begin
        cap      = {cfg_burst, {RATE_FRAC_BITS{1'b0}}};
        sum_w    = {1'b0, bucket_q} + SW'(cfg_rate);
        sub_w    = '0;
        if (release_i) begin
            sub_w = SW'({cost, {RATE_FRAC_BITS{1'b0}}});
        end
        diff_w   = (sum_w >= sub_w) ? (sum_w - sub_w) : '0;
        bucket_d = bucket_q;
        if (!cfg_enable) begin
            bucket_d = cap;
        end else if (diff_w > {1'b0, cap}) begin
            bucket_d = cap;
        end else begin
            bucket_d = diff_w[BUCKET_BITS-1:0];
        end
    end

    // Oversize records wait for a full bucket so they can never deadlock.
    always_comb begin
        bucket_int = bucket_q[BUCKET_BITS-1:RATE_FRAC_BITS];
        cost_ext   = BUCKET_WIDTH'(cost);
        oversize   = cost_ext > cfg_burst;
        token_ok   = 1'b0;
        if (!cfg_enable) begin
            token_ok = 1'b1;
        end else if (oversize) begin
            token_ok = (bucket_q == cap);
        end else begin
            token_ok = (bucket_int >= cost_ext);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bucket_q <= '0;
        end else begin
            bucket_q <= bucket_d;
        end
    end

endmodule

// File: rtl/dflow_tuple_pacer.sv
// Token-bucket byte-rate shaper between tuple generator and packet builder.
// Optional counters are built when DFLOW_PACER_STATS_EN is defined.
module dflow_tuple_pacer
    import dflow_gen_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_enable,
    input  logic [15:0]                cfg_rate,
    input  logic [BUCKET_WIDTH-1:0]    cfg_burst,
    input  logic [PKT_TUPLE_WIDTH-1:0] five_tuple_data_in,
    input  logic [PKT_LEN_WIDTH-1:0]   pkt_len_in,
    input  logic                       tuple_in_vld,
    output logic                       tuple_in_ready,
    output logic [PKT_TUPLE_WIDTH-1:0] five_tuple_data_out,
    output logic [PKT_LEN_WIDTH-1:0]   pkt_len_out,
    output logic                       tuple_out_vld,
    input  logic                       tuple_out_ready,
    output logic [31:0]                stat_pkt_cnt,
    output logic [47:0]                stat_byte_cnt,
    output logic [31:0]                stat_stall_cnt
);

    pacer_state_e            state_q;
    pacer_state_e            state_d;
    tuple_rec_t              hold_q;
    tuple_rec_t              hold_d;
    tuple_rec_t              out_q;
    tuple_rec_t              out_d;
    logic                    out_vld_q;
    logic                    out_vld_d;
    logic                    out_space;
    logic                    token_ok;
    logic                    rel;
    logic                    accept;
    logic [COST_WIDTH-1:0]   cost;

    always_comb begin
        cost = {1'b0, hold_q.len} + COST_WIDTH'(IFG_BYTES);
    end

    dflow_token_bucket u_bucket (
        .clk        (clk),
        .reset      (reset),
        .cfg_enable (cfg_enable),
        .cfg_rate   (cfg_rate),
        .cfg_burst  (cfg_burst),
        .cost       (cost),
        .release_i  (rel),
        .token_ok   (token_ok)
    );

    always_comb begin
        out_space      = !out_vld_q || tuple_out_ready;
        rel            = (state_q == PEND) && out_space && token_ok;
        tuple_in_ready = (state_q == IDLE) || rel;
        accept         = tuple_in_vld && tuple_in_ready;

        state_d = state_q;
        hold_d  = hold_q;
        if (accept) begin
            hold_d.tuple = five_tuple_data_in;
            hold_d.len   = pkt_len_in;
        end
        unique case (state_q)
            IDLE: if (accept) state_d = PEND;
            PEND: if (rel && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        out_d     = out_q;
        out_vld_d = out_vld_q;
        if (rel) begin
            out_d     = hold_q;
            out_vld_d = 1'b1;
        end else if (tuple_out_ready) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign five_tuple_data_out = out_q.tuple;
    assign pkt_len_out         = out_q.len;
    assign tuple_out_vld       = out_vld_q;

`ifdef DFLOW_PACER_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] pkt_cnt_d;
    logic [47:0] byte_cnt_q;
    logic [47:0] byte_cnt_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        pkt_cnt_d   = pkt_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (out_vld_q && tuple_out_ready) begin
            pkt_cnt_d  = pkt_cnt_q + 32'd1;
            byte_cnt_d = byte_cnt_q + 48'(out_q.len);
        end
        if ((state_q == PEND) && out_space && !token_ok) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            pkt_cnt_q   <= pkt_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_pkt_cnt   = pkt_cnt_q;
    assign stat_byte_cnt  = byte_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`else
    assign stat_pkt_cnt   = '0;
    assign stat_byte_cnt  = '0;
    assign stat_stall_cnt = '0;
`endif

endmodule
